// File: rtl/mmio_xbar_n_pkg.sv
// Shared MMIO definitions: bus widths, crossbar FSM encoding and the system address map.
package mmio_pkg;

  localparam int MMIO_ADDR_W = 30;
  localparam int MMIO_DATA_W = 32;
  localparam int MMIO_MASK_W = 4;

  // System address map: channel regions start at XBAR_BASE (word address).
  localparam logic [MMIO_ADDR_W-1:0] XBAR_BASE = 30'h100;
  localparam int CH_HEX   = 0;
  localparam int CH_LED   = 1;
  localparam int CH_TIMER = 2;
  localparam int CH_UART  = 3;

  typedef enum logic [1:0] {
    XBAR_IDLE   = 2'd0,
    XBAR_ACCESS = 2'd1,
    XBAR_RESP   = 2'd2
  } xbar_state_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_xbar_n_if.sv
// MMIO crossbar bus bundle: CPU-side request/response plus the per-channel select/ack side.
interface mmio_xbar_n_if #(
  parameter int NCH      = 4,
  parameter int REGION_W = 4
);
  import mmio_pkg::*;

  logic                       i_mmio_req;
  logic [MMIO_ADDR_W-1:0]     i_mmio_addr;
  logic [MMIO_DATA_W-1:0]     i_mmio_data;
  logic [MMIO_MASK_W-1:0]     i_mmio_mask;
  logic                       i_mmio_wren;
  logic                       o_mmio_ack;
  logic [MMIO_DATA_W-1:0]     o_mmio_data;
  logic                       o_mmio_err;
  logic [NCH-1:0]             o_ch_sel;
  logic [REGION_W-1:0]        o_ch_addr;
  logic [MMIO_DATA_W-1:0]     o_ch_data;
  logic [MMIO_MASK_W-1:0]     o_ch_mask;
  logic                       o_ch_wren;
  logic [NCH-1:0]             i_ch_ack;
  logic [NCH*MMIO_DATA_W-1:0] i_ch_rdata;

  // The crossbar itself.
  modport slave (
    input  i_mmio_req, i_mmio_addr, i_mmio_data, i_mmio_mask, i_mmio_wren,
    input  i_ch_ack, i_ch_rdata,
    output o_mmio_ack, o_mmio_data, o_mmio_err,
    output o_ch_sel, o_ch_addr, o_ch_data, o_ch_mask, o_ch_wren
  );

  // The environment: CPU memory stage plus the peripheral channels.
  modport master (
    output i_mmio_req, i_mmio_addr, i_mmio_data, i_mmio_mask, i_mmio_wren,
    output i_ch_ack, i_ch_rdata,
    input  o_mmio_ack, o_mmio_data, o_mmio_err,
    input  o_ch_sel, o_ch_addr, o_ch_data, o_ch_mask, o_ch_wren
  );

endinterface

// File: rtl/mmio_xbar_n_decode.sv
// Combinational address decode for the MMIO crossbar: word address -> {hit, idx, status_hit}.
// MMIO_XBAR_ERRSTAT_EN enables the status word just above the last channel region.
module mmio_xbar_decode
  import mmio_pkg::*;
#(
  parameter int                     NCH      = 4,
  parameter int                     REGION_W = 4,
  parameter logic [MMIO_ADDR_W-1:0] BASE     = 30'h100
) (
  input  logic [MMIO_ADDR_W-1:0]    i_addr,
  output logic                      o_hit,
  output logic [idx_width(NCH)-1:0] o_idx,
  output logic                      o_status_hit
);

  localparam int IDX_W = idx_width(NCH);
  // One extra bit so BASE + SPAN at the top of the space does not wrap.
  localparam logic [MMIO_ADDR_W:0] SPAN = NCH[MMIO_ADDR_W:0] << REGION_W;

  logic [MMIO_ADDR_W-1:0] off;

  always_comb begin
    off   = i_addr - BASE;
    o_hit = (i_addr >= BASE) && ({1'b0, off} < SPAN);
    o_idx = IDX_W'(off >> REGION_W);
`ifdef MMIO_XBAR_ERRSTAT_EN
    o_status_hit = ({1'b0, i_addr} == ({1'b0, BASE} + SPAN));
`else
    o_status_hit = 1'b0;
`endif
  end

endmodule

// File: rtl/mmio_xbar_n.sv
// Registered MMIO crossbar: decodes CPU word accesses onto NCH channels with select/ack and timeout.
// Define MMIO_XBAR_ERRSTAT_EN to add the error-count/last-error-address status word.
module mmio_xbar_n
  import mmio_pkg::*;
#(
  parameter int                     NCH      = 4,
  parameter int                     REGION_W = 4,
  parameter logic [MMIO_ADDR_W-1:0] BASE     = 30'h100,
  parameter int                     TIMEOUT  = 15
) (
  input logic          i_clk,
  input logic          i_rst,
  mmio_xbar_n_if.slave bus
);

  localparam int IDX_W = idx_width(NCH);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  xbar_state_e            state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   wren_q, wren_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic [MMIO_DATA_W-1:0] rdata_q, rdata_d;
  logic [NCH-1:0]         sel_q, sel_d;
  logic [REGION_W-1:0]    ch_addr_q, ch_addr_d;
  logic [MMIO_DATA_W-1:0] ch_data_q, ch_data_d;
  logic [MMIO_MASK_W-1:0] ch_mask_q, ch_mask_d;
  logic                   ch_wren_q, ch_wren_d;
  logic                   ch_clr;

  logic                   dec_hit;
  logic [IDX_W-1:0]       dec_idx;
  logic                   dec_stat;

  mmio_xbar_decode #(
    .NCH      (NCH),
    .REGION_W (REGION_W),
    .BASE     (BASE)
  ) u_decode (
    .i_addr       (bus.i_mmio_addr),
    .o_hit        (dec_hit),
    .o_idx        (dec_idx),
    .o_status_hit (dec_stat)
  );

`ifdef MMIO_XBAR_ERRSTAT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] err_addr_q, err_addr_d;
  logic [15:0] addr_q, addr_d;

  // err_d is only ever set on the cycle that enters RESP with an error.
  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    addr_d     = addr_q;
    if (state_q == XBAR_IDLE && bus.i_mmio_req) addr_d = bus.i_mmio_addr[15:0];
    if (state_q == XBAR_IDLE && bus.i_mmio_req && dec_stat && bus.i_mmio_wren) begin
      err_cnt_d  = '0;
      err_addr_d = '0;
    end else if (err_d) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      err_addr_d = (state_q == XBAR_IDLE) ? bus.i_mmio_addr[15:0] : addr_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      addr_q     <= '0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      addr_q     <= addr_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wren_d    = wren_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    sel_d     = sel_q;
    ch_addr_d = ch_addr_q;
    ch_data_d = ch_data_q;
    ch_mask_d = ch_mask_q;
    ch_wren_d = ch_wren_q;
    ch_clr    = 1'b0;
    unique case (state_q)
      XBAR_IDLE: begin
        if (bus.i_mmio_req) begin
          wren_d = bus.i_mmio_wren;
          idx_d  = dec_idx;
          cnt_d  = '0;
`ifdef MMIO_XBAR_ERRSTAT_EN
          if (dec_stat) begin
            state_d = XBAR_RESP;
            ack_d   = 1'b1;
            if (!bus.i_mmio_wren) rdata_d = {err_addr_q, err_cnt_q};
          end else
`endif
          // The status word never overlaps a channel; without the status feature it is unmapped.
          if (!dec_hit || dec_stat) begin
            state_d = XBAR_RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else if (bus.i_mmio_wren && bus.i_mmio_mask == '0) begin
            state_d = XBAR_RESP;
            ack_d   = 1'b1;
          end else begin
            state_d   = XBAR_ACCESS;
            sel_d     = NCH'(1) << dec_idx;
            ch_addr_d = bus.i_mmio_addr[REGION_W-1:0];
            ch_data_d = bus.i_mmio_data;
            ch_mask_d = bus.i_mmio_mask;
            ch_wren_d = bus.i_mmio_wren;
          end
        end
      end
      XBAR_ACCESS: begin
        // Ack is checked before the timeout so a last-cycle ack still completes cleanly.
        if (bus.i_ch_ack[idx_q]) begin
          state_d = XBAR_RESP;
          ack_d   = 1'b1;
          ch_clr  = 1'b1;
          if (!wren_q) rdata_d = bus.i_ch_rdata[MMIO_DATA_W*idx_q +: MMIO_DATA_W];
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          state_d = XBAR_RESP;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          ch_clr  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      XBAR_RESP: state_d = XBAR_IDLE;
      default:   state_d = XBAR_IDLE;
    endcase
    if (ch_clr) begin
      sel_d     = '0;
      ch_addr_d = '0;
      ch_data_d = '0;
      ch_mask_d = '0;
      ch_wren_d = 1'b0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= XBAR_IDLE;
      idx_q     <= '0;
      wren_q    <= 1'b0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      sel_q     <= '0;
      ch_addr_q <= '0;
      ch_data_q <= '0;
      ch_mask_q <= '0;
      ch_wren_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wren_q    <= wren_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      sel_q     <= sel_d;
      ch_addr_q <= ch_addr_d;
      ch_data_q <= ch_data_d;
      ch_mask_q <= ch_mask_d;
      ch_wren_q <= ch_wren_d;
    end
  end

  assign bus.o_mmio_ack  = ack_q;
  assign bus.o_mmio_err  = err_q;
  assign bus.o_mmio_data = rdata_q;
  assign bus.o_ch_sel    = sel_q;
  assign bus.o_ch_addr   = ch_addr_q;
  assign bus.o_ch_data   = ch_data_q;
  assign bus.o_ch_mask   = ch_mask_q;
  assign bus.o_ch_wren   = ch_wren_q;

endmodule

// File: tb/tb_mmio_xbar_n.sv
// Scoreboard bench for mmio_xbar_n: directed accesses push expected channel/CPU responses into queues.
// Status-word checks are built only when MMIO_XBAR_ERRSTAT_EN is defined.
module tb_mmio_xbar_n;
  import mmio_pkg::*;

  localparam int NCH      = 4;
  localparam int REGION_W = 4;
  localparam int TIMEOUT  = 15;
`ifdef MMIO_XBAR_ERRSTAT_EN
  localparam logic STAT_EN = 1'b1;
`else
  localparam logic STAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mmio_xbar_n_if #(.NCH(NCH), .REGION_W(REGION_W)) bus ();

  mmio_xbar_n #(
    .NCH      (NCH),
    .REGION_W (REGION_W),
    .BASE     (30'h100),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [29:0] dk_addr;
  logic        dk_hit;
  logic [1:0]  dk_idx;
  logic        dk_stat;
  mmio_xbar_decode #(.NCH(NCH), .REGION_W(REGION_W), .BASE(30'h100)) u_dk (
    .i_addr (dk_addr), .o_hit (dk_hit), .o_idx (dk_idx), .o_status_hit (dk_stat)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int txn_id = 0;

  typedef struct { logic [31:0] data; logic err; int lat; int t0; int id; } resp_t;
  typedef struct { logic [3:0] sel; logic [3:0] addr; logic [31:0] data; logic [3:0] mask; logic wren; int hold; } chx_t;
  resp_t respq[$];
  chx_t  chq[$];

  // Peripheral model: channel k acks in its lat_cfg[k]-th select cycle (0 = never).
  int          lat_cfg [NCH];
  logic [31:0] rd_cfg  [NCH];
  logic [3:0]  stray = '0;
  int          sel_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) sel_cnt <= 0;
    else if (|bus.o_ch_sel) sel_cnt <= sel_cnt + 1;
    else sel_cnt <= 0;
  end

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      bus.i_ch_ack[k] = stray[k] | (bus.o_ch_sel[k] && lat_cfg[k] != 0 && sel_cnt == lat_cfg[k] - 1);
      bus.i_ch_rdata[32*k +: 32] = rd_cfg[k];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_ch(input logic [3:0] sel, input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic w, input int hold);
    chx_t c;
    c.sel = sel; c.addr = a; c.data = d; c.mask = m; c.wren = w; c.hold = hold;
    chq.push_back(c);
  endtask

  task automatic do_txn(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m, input logic w,
                        input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    resp_t r;
    int n;
    @(negedge clk);
    txn_id++;
    r.data = exp_data; r.err = exp_err; r.lat = exp_lat; r.t0 = cyc; r.id = txn_id;
    respq.push_back(r);
    bus.i_mmio_addr = a; bus.i_mmio_data = d; bus.i_mmio_mask = m; bus.i_mmio_wren = w;
    bus.i_mmio_req  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_mmio_ack && n < 40);
    if (!bus.o_mmio_ack) begin
      checks++;
      errors++;
      $display("FAIL ack wait txn %0d: actual=no ack in 40 cycles required=ack", txn_id);
      respq.delete();
    end
    @(posedge clk);
    #1 bus.i_mmio_req = 1'b0;
  endtask

  task automatic dec_vec(input logic [29:0] a, input logic hit, input logic [1:0] idx, input logic st);
    dk_addr = a;
    #1;
    chk("decode hit", {31'd0, dk_hit}, {31'd0, hit});
    if (hit) chk("decode idx", {30'd0, dk_idx}, {30'd0, idx});
    chk("decode status", {31'd0, dk_stat}, {31'd0, st});
  endtask

  // Response monitor: every ack pops one expected response.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (bus.o_mmio_ack) begin
        if (respq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected ack: actual=ack data=%h required=no ack", bus.o_mmio_data);
        end else begin
          r = respq.pop_front();
          chk("resp data", bus.o_mmio_data, r.data);
          chk("resp err", {31'd0, bus.o_mmio_err}, {31'd0, r.err});
          chk("resp latency", cyc - r.t0 + 1, r.lat);
          chk("sel in resp", {28'd0, bus.o_ch_sel}, 32'd0);
          $display("txn %0d: data=%h err=%b lat=%0d", r.id, bus.o_mmio_data, bus.o_mmio_err, cyc - r.t0 + 1);
        end
      end
    end
  end

  // Channel monitor: each new select pops one expected channel access and checks it while held.
  initial begin
    logic [3:0] prev_sel = '0;
    int   held = 0;
    logic have = 1'b0;
    chx_t cur;
    forever begin
      @(negedge clk);
      if (bus.o_ch_sel != 0 && prev_sel == 0) begin
        if (chq.size() == 0) begin
          have = 1'b0;
          checks++;
          errors++;
          $display("FAIL unexpected select: actual=%b required=none", bus.o_ch_sel);
        end else begin
          cur  = chq.pop_front();
          have = 1'b1;
          held = 1;
          chk("ch sel", {28'd0, bus.o_ch_sel}, {28'd0, cur.sel});
          chk("ch addr", {28'd0, bus.o_ch_addr}, {28'd0, cur.addr});
          chk("ch data", bus.o_ch_data, cur.data);
          chk("ch mask", {28'd0, bus.o_ch_mask}, {28'd0, cur.mask});
          chk("ch wren", {31'd0, bus.o_ch_wren}, {31'd0, cur.wren});
        end
      end else if (bus.o_ch_sel != 0) begin
        held++;
        if (have) chk("ch sel hold", {28'd0, bus.o_ch_sel}, {28'd0, cur.sel});
      end else if (prev_sel != 0 && have) begin
        if (cur.hold != 0) chk("ch sel cycles", held, cur.hold);
        have = 1'b0;
      end
      prev_sel = bus.o_ch_sel;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_mmio_req = 1'b0; bus.i_mmio_addr = '0; bus.i_mmio_data = '0;
    bus.i_mmio_mask = '0;  bus.i_mmio_wren = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      lat_cfg[k] = 1;
      rd_cfg[k]  = '0;
    end

    // Decoder vectors around the region edges.
    dec_vec(30'h0FF, 1'b0, 2'd0, 1'b0);
    dec_vec(30'h100, 1'b1, 2'd0, 1'b0);
    dec_vec(30'h11F, 1'b1, 2'd1, 1'b0);
    dec_vec(30'h13F, 1'b1, 2'd3, 1'b0);
    dec_vec(30'h140, 1'b0, 2'd0, STAT_EN);
    dec_vec(30'h3FFFFFFF, 1'b0, 2'd0, 1'b0);

    repeat (3) @(negedge clk);
    chk("rst ack", {31'd0, bus.o_mmio_ack}, 32'd0);
    chk("rst err", {31'd0, bus.o_mmio_err}, 32'd0);
    chk("rst data", bus.o_mmio_data, 32'd0);
    chk("rst sel", {28'd0, bus.o_ch_sel}, 32'd0);
    chk("rst ch_data", bus.o_ch_data, 32'd0);
    rst = 1'b0;

    // Write hit on ch1, combinational ack; write data is never returned.
    rd_cfg[1] = 32'h1111_1111;
    push_ch(4'b0010, 4'h2, 32'h0000_BEEF, 4'hF, 1'b1, 1);
    do_txn(30'h112, 32'h0000_BEEF, 4'hF, 1'b1, 32'h0, 1'b0, 3);

    // Read hit on ch3 with a 5-cycle ack, while ch0 acks spuriously.
    rd_cfg[3] = 32'hCAFE_0123; lat_cfg[3] = 5; stray = 4'b0001;
    push_ch(4'b1000, 4'hF, 32'h0, 4'hF, 1'b0, 5);
    do_txn(30'h13F, 32'h0, 4'hF, 1'b0, 32'hCAFE_0123, 1'b0, 7);
    stray = 4'b0000;

    // ch2 never acks: 15 access cycles then error.
    rd_cfg[2] = 32'h2222_2222; lat_cfg[2] = 0;
    push_ch(4'b0100, 4'h0, 32'h0, 4'hF, 1'b0, TIMEOUT);
    do_txn(30'h120, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1, TIMEOUT + 2);

    // Misses on both sides of the map and a mask-0 write.
    do_txn(30'h200, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1, 2);
    do_txn(30'h0FF, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1, 2);
    do_txn(30'h100, 32'h5555_AAAA, 4'h0, 1'b1, 32'h0, 1'b0, 2);

    // Read with partial mask, 2-cycle ack on ch0.
    rd_cfg[0] = 32'h0BAD_F00D; lat_cfg[0] = 2;
    push_ch(4'b0001, 4'hF, 32'h0, 4'h3, 1'b0, 2);
    do_txn(30'h10F, 32'h0, 4'h3, 1'b0, 32'h0BAD_F00D, 1'b0, 4);

    // Write to a channel whose read data is non-zero still returns 0.
    lat_cfg[3] = 1;
    push_ch(4'b1000, 4'hF, 32'h1234_5678, 4'h5, 1'b1, 1);
    do_txn(30'h13F, 32'h1234_5678, 4'h5, 1'b1, 32'h0, 1'b0, 3);

    // Back-to-back writes: the second is presented in the IDLE cycle right after RESP.
    lat_cfg[0] = 1;
    push_ch(4'b0001, 4'h1, 32'hA0A0_0001, 4'hF, 1'b1, 1);
    push_ch(4'b0010, 4'h5, 32'hB0B0_0002, 4'hC, 1'b1, 1);
    do_txn(30'h101, 32'hA0A0_0001, 4'hF, 1'b1, 32'h0, 1'b0, 3);
    do_txn(30'h115, 32'hB0B0_0002, 4'hC, 1'b1, 32'h0, 1'b0, 3);
    @(negedge clk);
    chk("idle ch_data", bus.o_ch_data, 32'd0);
    chk("idle ch_mask", {28'd0, bus.o_ch_mask}, 32'd0);
    chk("idle ch_wren", {31'd0, bus.o_ch_wren}, 32'd0);

`ifdef MMIO_XBAR_ERRSTAT_EN
    do_txn(30'h140, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, 2);
    do_txn(30'h200, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1, 2);
    do_txn(30'h201, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1, 2);
    do_txn(30'h140, 32'h0, 4'hF, 1'b0, 32'h0201_0002, 1'b0, 2);
    do_txn(30'h140, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 1'b0, 2);
    do_txn(30'h140, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 2);
`else
    do_txn(30'h140, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1, 2);
`endif

    // Reset during ACCESS aborts the access with no ack.
    push_ch(4'b0100, 4'h5, 32'h0, 4'hF, 1'b0, 0);
    @(negedge clk);
    bus.i_mmio_addr = 30'h125; bus.i_mmio_data = '0; bus.i_mmio_mask = 4'hF;
    bus.i_mmio_wren = 1'b0;    bus.i_mmio_req  = 1'b1;
    repeat (3) @(negedge clk);
    chk("sel before reset", {28'd0, bus.o_ch_sel}, 32'h4);
    #1 rst = 1'b1;
    #1;
    chk("async reset sel", {28'd0, bus.o_ch_sel}, 32'd0);
    chk("async reset ack", {31'd0, bus.o_mmio_ack}, 32'd0);
    bus.i_mmio_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post reset sel", {28'd0, bus.o_ch_sel}, 32'd0);
    chk("post reset ch_addr", {28'd0, bus.o_ch_addr}, 32'd0);

    // FSM is back in IDLE: a normal hit completes with normal latency.
    push_ch(4'b0010, 4'h2, 32'h0, 4'hF, 1'b0, 1);
    do_txn(30'h112, 32'h0, 4'hF, 1'b0, 32'h1111_1111, 1'b0, 3);

    repeat (4) @(negedge clk);
    chk("resp queue drained", respq.size(), 32'd0);
    chk("ch queue drained", chq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
